reg_wb_arbiter: RTL and testbench

Arbitrates the single write port of the 32×32 register file between two writeback requesters (req0: execute/ALU commit, req1: load/MMIO return) using a valid/ready handshake and round-robin priority. Drives the register file's `wen`/`waddr`/`wdata` from a registered output stage. Optionally keeps a 32-bit pending-write scoreboard that the decode stage queries for RAW hazards.

---
 rtl/reg_wb_arbiter.sv | 95 +++++++++
 tb/tb_reg_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin writeback arbiter for the register file write port.
// Define REG_WB_SCOREBOARD_EN to build the pending-write scoreboard (busy bits, busy_cnt, chk_busy*).
module reg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic                  claim_valid,
   input  logic [ADDR_WIDTH-1:0] claim_addr,
   input  logic [ADDR_WIDTH-1:0] chk_addr1,
   input  logic [ADDR_WIDTH-1:0] chk_addr2,
   output logic                  chk_busy1,
   output logic                  chk_busy2,
   output logic [5:0]            busy_cnt
);
   logic                  prio;
   logic                  grant0, grant1, xfer;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   always_comb begin
      grant0   = !rst && req0_valid && (!req1_valid || !prio);
      grant1   = !rst && req1_valid && (!req0_valid || prio);
      xfer     = grant0 || grant1;
      sel_addr = grant0 ? req0_addr : req1_addr;
      sel_data = grant0 ? req0_data : req1_data;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Writes to x0 are accepted and rotate priority but never reach the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         prio     <= 1'b0;
      end else begin
         rf_wen <= xfer && (sel_addr != '0);
         if (xfer) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            prio     <= grant0;
         end
      end
   end

`ifdef REG_WB_SCOREBOARD_EN
   localparam int NREG = 1 << ADDR_WIDTH;
   logic [NREG-1:0] busy, busy_next;
   logic [5:0]      cnt_next;

   // A claim overrides a same-cycle clear: the new producer owns the register.
   always_comb begin
      busy_next = busy;
      if (rf_wen) busy_next[rf_waddr] = 1'b0;
      if (claim_valid && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
      busy_next[0] = 1'b0;
      cnt_next = '0;
      for (int i = 0; i < NREG; i++) cnt_next = cnt_next + 6'(busy_next[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   assign chk_busy1 = busy[chk_addr1];
   assign chk_busy2 = busy[chk_addr2];
`else
   logic unused_scoreboard;
   assign unused_scoreboard = ^{claim_valid, claim_addr, chk_addr1, chk_addr2};
   assign chk_busy1 = 1'b0;
   assign chk_busy2 = 1'b0;
   assign busy_cnt  = '0;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed and randomized checks of reg_wb_arbiter against a behavioural model.
// Expectations follow REG_WB_SCOREBOARD_EN the same way the design does.
module tb_reg_wb_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [4:0]  req0_addr = 0, req1_addr = 0;
   logic [31:0] req0_data = 0, req1_data = 0;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        claim_valid = 0;
   logic [4:0]  claim_addr = 0, chk_addr1 = 0, chk_addr2 = 0;
   logic        chk_busy1, chk_busy2;
   logic [5:0]  busy_cnt;

`ifdef REG_WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   reg_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .claim_valid(claim_valid), .claim_addr(claim_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   bit          m_prio, m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   bit          m_busy [32];
   bit          e_g0, e_g1, e_b1, e_b2;
   logic        o_r0, o_r1, o_b1, o_b2;

   function automatic logic [5:0] m_cnt();
      int s = 0;
      foreach (m_busy[i]) s += int'(m_busy[i]);
      return 6'(s);
   endfunction

   // One clock: drive on negedge, capture combinational outputs, advance the model at posedge.
   task automatic cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        input bit cv, input logic [4:0] ca, input logic [4:0] c1, input logic [4:0] c2);
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      claim_valid = cv; claim_addr = ca; chk_addr1 = c1; chk_addr2 = c2;
      #1;
      o_r0 = req0_ready; o_r1 = req1_ready; o_b1 = chk_busy1; o_b2 = chk_busy2;
      e_g0 = !rst && v0 && (!v1 || !m_prio);
      e_g1 = !rst && v1 && (!v0 || m_prio);
      e_b1 = m_busy[c1]; e_b2 = m_busy[c2];
      @(posedge clk);
      if (rst) begin
         m_prio = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
         foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
         if (m_wen) m_busy[m_waddr] = 0;
         if (SB && cv && ca != 0) m_busy[ca] = 1;
         m_wen = (e_g0 || e_g1) && ((e_g0 ? a0 : a1) != 0);
         if (e_g0 || e_g1) begin
            m_waddr = e_g0 ? a0 : a1;
            m_wdata = e_g0 ? d0 : d1;
            m_prio  = e_g0;
         end
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] c1 = 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
   endtask

   task automatic test_reset();
      rst = 1;
      cycle(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if ({o_r0, o_r1} !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b%b exp=00", o_r0, o_r1); end
      cycle(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if ({rf_wen, rf_waddr, rf_wdata, busy_cnt} !== 44'd0) begin
         fails++; $display("FAIL reset_state got wen=%b addr=%0d data=%h cnt=%0d exp all 0", rf_wen, rf_waddr, rf_wdata, busy_cnt);
      end
      rst = 0;
      idle();
   endtask

   task automatic test_single();
      cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if ({o_r0, o_r1} !== 2'b10) begin fails++; $display("FAIL single_ready got=%b%b exp=10", o_r0, o_r1); end
      tests++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
         fails++; $display("FAIL single_out got wen=%b addr=%0d data=%h exp 1/5/1234", rf_wen, rf_waddr, rf_wdata);
      end
      idle();
      tests++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h1234}) begin
         fails++; $display("FAIL single_hold got wen=%b addr=%0d data=%h exp 0/5/1234", rf_wen, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_alternate();
      int n0 = 0, n1 = 0;
      rst = 1; idle(); rst = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(n0 < 2, 1, 32'hA0, n1 < 2, 2, 32'hB0, 0, 0, 0, 0);
         if (o_r0 === 1'b1) n0++;
         if (o_r1 === 1'b1) n1++;
         tests++;
         if ({o_r0, o_r1} !== ((k % 2) != 0 ? 2'b01 : 2'b10)) begin
            fails++; $display("FAIL alt_grant k=%0d got=%b%b exp port%0d", k, o_r0, o_r1, k % 2);
         end
         tests++;
         if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, (k % 2) != 0 ? 5'd2 : 5'd1, (k % 2) != 0 ? 32'hB0 : 32'hA0}) begin
            fails++; $display("FAIL alt_waddr k=%0d got wen=%b addr=%0d exp addr=%0d", k, rf_wen, rf_waddr, (k % 2) + 1);
         end
      end
   endtask

   task automatic test_addr0();
      cycle(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
      tests++;
      if ({o_r0, o_r1} !== 2'b01) begin fails++; $display("FAIL addr0_ready got=%b%b exp=01", o_r0, o_r1); end
      tests++;
      if (rf_wen !== 1'b0) begin fails++; $display("FAIL addr0_wen got=%b exp=0", rf_wen); end
      cycle(1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 0, 0);
      tests++;
      if ({o_r0, o_r1} !== 2'b10) begin fails++; $display("FAIL addr0_prio got=%b%b exp=10", o_r0, o_r1); end
      cycle(0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0);
      idle();
   endtask

   task automatic test_scoreboard();
      cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      tests++;
      if (o_b1 !== 1'b0) begin fails++; $display("FAIL sb_before got=%b exp=0", o_b1); end
      tests++;
      if (busy_cnt !== 6'(SB)) begin fails++; $display("FAIL sb_cnt_claim got=%0d exp=%0d", busy_cnt, SB); end
      idle(7);
      tests++;
      if (o_b1 !== SB) begin fails++; $display("FAIL sb_busy_c1 got=%b exp=%b", o_b1, SB); end
      idle(7);
      cycle(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      tests++;
      if ({o_b1, rf_wen} !== {SB, 1'b0}) begin fails++; $display("FAIL sb_busy_c4 got busy=%b wen=%b exp busy=%b wen=0", o_b1, rf_wen, SB); end
      idle(7);
      tests++;
      if ({o_b1, busy_cnt} !== 7'd0) begin fails++; $display("FAIL sb_clear got busy=%b cnt=%0d exp 0/0", o_b1, busy_cnt); end
   endtask

   task automatic test_same_cycle();
      cycle(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 0);
      tests++;
      if ({rf_wen, rf_waddr} !== {1'b1, 5'd9}) begin fails++; $display("FAIL same_out got wen=%b addr=%0d exp 1/9", rf_wen, rf_waddr); end
      cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      tests++;
      if (busy_cnt !== 6'(SB)) begin fails++; $display("FAIL same_cnt got=%0d exp=%0d", busy_cnt, SB); end
      idle(9);
      tests++;
      if (o_b1 !== SB) begin fails++; $display("FAIL same_busy got=%b exp=%b", o_b1, SB); end
   endtask

   task automatic test_reset_mid();
      cycle(1, 11, 32'hBB, 0, 0, 0, 1, 11, 0, 0);
      rst = 1;
      cycle(1, 12, 32'hCC, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if ({o_r0, rf_wen, busy_cnt} !== 8'd0) begin
         fails++; $display("FAIL rstmid got ready=%b wen=%b cnt=%0d exp 0/0/0", o_r0, rf_wen, busy_cnt);
      end
      rst = 0;
      cycle(1, 12, 32'hCC, 1, 13, 32'hDD, 0, 0, 11, 0);
      tests++;
      if ({o_r0, o_r1, o_b1} !== 3'b100) begin fails++; $display("FAIL rstmid_prio got=%b%b busy=%b exp=10 busy=0", o_r0, o_r1, o_b1); end
      cycle(0, 0, 0, 1, 13, 32'hDD, 0, 0, 0, 0);
      idle();
   endtask

   task automatic test_random();
      bit p0 = 0, p1 = 0;
      logic [4:0] a0 = 0, a1 = 0;
      logic [31:0] d0 = 0, d1 = 0;
      int bad = 0;
      for (int n = 0; n < 400; n++) begin
         if (!p0 && $urandom_range(2) != 0) begin p0 = 1; a0 = 5'($urandom); d0 = $urandom; end
         if (!p1 && $urandom_range(2) != 0) begin p1 = 1; a1 = 5'($urandom); d1 = $urandom; end
         cycle(p0, a0, d0, p1, a1, d1, $urandom_range(3) == 0, 5'($urandom), 5'($urandom), 5'($urandom));
         if (e_g0) p0 = 0;
         if (e_g1) p1 = 0;
         tests++;
         if ({o_r0, o_r1, o_b1, o_b2} !== {e_g0, e_g1, e_b1, e_b2}) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL rand_comb n=%0d got=%b%b%b%b exp=%b%b%b%b", n, o_r0, o_r1, o_b1, o_b2, e_g0, e_g1, e_b1, e_b2);
         end
         tests++;
         if ({rf_wen, busy_cnt} !== {m_wen, m_cnt()} || (m_wen && {rf_waddr, rf_wdata} !== {m_waddr, m_wdata})) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL rand_out n=%0d got wen=%b addr=%0d data=%h cnt=%0d exp wen=%b addr=%0d data=%h cnt=%0d",
                                   n, rf_wen, rf_waddr, rf_wdata, busy_cnt, m_wen, m_waddr, m_wdata, m_cnt());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_addr0();
      test_scoreboard();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
